// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-SRAM arbiter, its two requesters and the SRAM.
// The slave modport is the arbiter's view; master is the environment side
// (CPU, DMA and SRAM together).
interface dmem_arbiter_if #(
    parameter int N = 4,
    parameter int A = 4
);
    logic         cpu_req;
    logic         cpu_we;
    logic [A-1:0] cpu_addr;
    logic [N-1:0] cpu_wdata;
    logic         cpu_gnt;
    logic         cpu_rvalid;

    logic         dma_req;
    logic         dma_we;
    logic [A-1:0] dma_addr;
    logic [N-1:0] dma_wdata;
    logic         dma_gnt;
    logic         dma_rvalid;

    logic [N-1:0] rdata;
    logic         busy;

    logic         sram_ren;
    logic         sram_wen;
    logic [A-1:0] sram_addr;
    logic [N-1:0] sram_wdata;
    logic [N-1:0] sram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  sram_rdata,
        output cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
        output rdata, busy,
        output sram_ren, sram_wen, sram_addr, sram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output sram_rdata,
        input  cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
        input  rdata, busy,
        input  sram_ren, sram_wen, sram_addr, sram_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data SRAM arbiter shared by the CPU and a DMA/loader.
// CPU has priority; the DMA may keep the SRAM for at most MAX_BURST grants
// while the CPU is waiting. Read data returns one cycle after the grant,
// tagged to the requester that issued the read.
//
//   owner     | meaning
//   ----------+-----------------------------------------------------------
//   OWN_IDLE  | no grant last cycle
//   OWN_CPU   | CPU won last cycle; a contending DMA loses next cycle
//   OWN_DMA   | DMA burst in progress; keeps winning until burst_cnt hits max
module dmem_arbiter #(
    parameter int N         = 4,
    parameter int A         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    dmem_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_DMA} owner_t;

    owner_t        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_vld_q, pend_vld_d;
    logic          pend_dma_q, pend_dma_d;
    logic [N-1:0]  rdata_q, rdata_d;
    logic          gnt_cpu, gnt_dma;

    // State register: owner, burst counter, pending read tag, held read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= OWN_IDLE;
            cnt_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_dma_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_dma_q <= pend_dma_d;
            rdata_q    <= rdata_d;
        end
    end

    // Arbitration and next state; grants are suppressed while rst is high
    // so every output reads 0 during reset.
    always_comb begin
        gnt_cpu    = 1'b0;
        gnt_dma    = 1'b0;
        owner_d    = OWN_IDLE;
        cnt_d      = '0;
        pend_vld_d = 1'b0;
        pend_dma_d = pend_dma_q;
        rdata_d    = pend_vld_q ? bus.sram_rdata : rdata_q;

        if (!rst) begin
            if (bus.cpu_req && bus.dma_req) begin
                if (owner_q == OWN_DMA && cnt_q < CNT_MAX) gnt_dma = 1'b1;
                else                                       gnt_cpu = 1'b1;
            end else if (bus.cpu_req) begin
                gnt_cpu = 1'b1;
            end else if (bus.dma_req) begin
                gnt_dma = 1'b1;
            end
        end

        if (gnt_cpu) begin
            owner_d    = OWN_CPU;
            pend_vld_d = !bus.cpu_we;
            pend_dma_d = 1'b0;
        end else if (gnt_dma) begin
            owner_d    = OWN_DMA;
            pend_vld_d = !bus.dma_we;
            pend_dma_d = 1'b1;
            // Only DMA grants that keep a CPU waiting count toward the bound.
            if (bus.cpu_req)
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
    end

    // Output drive: SRAM command from the winner, tagged read return.
    always_comb begin
        bus.cpu_gnt    = gnt_cpu;
        bus.dma_gnt    = gnt_dma;
        bus.sram_ren   = 1'b0;
        bus.sram_wen   = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        if (gnt_cpu) begin
            bus.sram_ren   = !bus.cpu_we;
            bus.sram_wen   = bus.cpu_we;
            bus.sram_addr  = bus.cpu_addr;
            bus.sram_wdata = bus.cpu_wdata;
        end else if (gnt_dma) begin
            bus.sram_ren   = !bus.dma_we;
            bus.sram_wen   = bus.dma_we;
            bus.sram_addr  = bus.dma_addr;
            bus.sram_wdata = bus.dma_wdata;
        end
        bus.cpu_rvalid = pend_vld_q && !pend_dma_q;
        bus.dma_rvalid = pend_vld_q && pend_dma_q;
        bus.rdata      = pend_vld_q ? bus.sram_rdata : rdata_q;
        bus.busy       = (owner_q == OWN_DMA);
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with an SRAM model and a cycle-level
// reference model of the arbitration rules.
module tb_dmem_arbiter;
    localparam int N = 4;
    localparam int A = 4;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    dmem_arbiter_if #(.N(N), .A(A)) bus ();

    dmem_arbiter #(.N(N), .A(A), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM: data appears the cycle after sram_ren.
    logic [N-1:0] sram_mem [16] = '{default: '0};
    initial bus.sram_rdata = '0;
    always @(posedge clk) begin
        if (bus.sram_wen) sram_mem[bus.sram_addr] <= bus.sram_wdata;
        if (bus.sram_ren) bus.sram_rdata <= sram_mem[bus.sram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: DMA may win a contended cycle only while it is the
    // current owner and has not yet used MAX_BURST grants against a waiting CPU.
    int           m_run = 0;
    bit           m_dma_own = 0;
    int           m_pend = 0;          // 0 none, 1 cpu, 2 dma
    logic [N-1:0] m_pval = '0;
    logic [N-1:0] m_hold = '0;
    logic [N-1:0] m_mem [16] = '{default: '0};

    always @(negedge clk) begin
        bit dw, cw;
        if (rst) begin
            check("rst_cpu_gnt", 32'(bus.cpu_gnt), 0);
            check("rst_dma_gnt", 32'(bus.dma_gnt), 0);
            check("rst_rvalid", 32'({bus.cpu_rvalid, bus.dma_rvalid}), 0);
            check("rst_rdata", 32'(bus.rdata), 0);
            check("rst_busy", 32'(bus.busy), 0);
            check("rst_sram", 32'({bus.sram_ren, bus.sram_wen, bus.sram_addr, bus.sram_wdata}), 0);
            m_run = 0; m_dma_own = 0; m_pend = 0; m_hold = '0;
        end else begin
            dw = bus.dma_req && (!bus.cpu_req || (m_dma_own && m_run < MAX_BURST));
            cw = bus.cpu_req && !dw;
            check("m_cpu_gnt", 32'(bus.cpu_gnt), 32'(cw));
            check("m_dma_gnt", 32'(bus.dma_gnt), 32'(dw));
            if (cw) begin
                check("m_sram_cmd", 32'({bus.sram_ren, bus.sram_wen, bus.sram_addr, bus.sram_wdata}),
                      32'({!bus.cpu_we, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata}));
            end else if (dw) begin
                check("m_sram_cmd", 32'({bus.sram_ren, bus.sram_wen, bus.sram_addr, bus.sram_wdata}),
                      32'({!bus.dma_we, bus.dma_we, bus.dma_addr, bus.dma_wdata}));
            end else begin
                check("m_sram_idle", 32'({bus.sram_ren, bus.sram_wen, bus.sram_addr, bus.sram_wdata}), 0);
            end
            check("m_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(m_pend == 1));
            check("m_dma_rvalid", 32'(bus.dma_rvalid), 32'(m_pend == 2));
            check("m_rdata", 32'(bus.rdata), 32'((m_pend != 0) ? m_pval : m_hold));
            check("m_busy", 32'(bus.busy), 32'(m_dma_own));

            if (m_pend != 0) m_hold = m_pval;
            m_pend = 0;
            if (cw) begin
                if (bus.cpu_we) m_mem[bus.cpu_addr] = bus.cpu_wdata;
                else begin m_pend = 1; m_pval = m_mem[bus.cpu_addr]; end
            end else if (dw) begin
                if (bus.dma_we) m_mem[bus.dma_addr] = bus.dma_wdata;
                else begin m_pend = 2; m_pval = m_mem[bus.dma_addr]; end
            end
            if (dw) begin
                m_dma_own = 1;
                m_run = bus.cpu_req ? ((m_run + 1 > MAX_BURST) ? MAX_BURST : m_run + 1) : 0;
            end else begin
                m_dma_own = 0;
                m_run = 0;
            end
        end
    end

    task automatic drive(input logic c_req, input logic c_we, input logic [3:0] c_a, input logic [3:0] c_d,
                         input logic d_req, input logic d_we, input logic [3:0] d_a, input logic [3:0] d_d);
        @(posedge clk); #1;
        bus.cpu_req = c_req; bus.cpu_we = c_we; bus.cpu_addr = c_a; bus.cpu_wdata = c_d;
        bus.dma_req = d_req; bus.dma_we = d_we; bus.dma_addr = d_a; bus.dma_wdata = d_d;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndma;
        bit got_cpu;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
        rst = 1;
        repeat (2) @(negedge clk);
        // A request during reset must not be granted.
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 4'h3; bus.cpu_wdata = 4'h5;
        @(negedge clk);
        check("lit_rst_no_gnt", 32'(bus.cpu_gnt), 0);

        // Release with the CPU write already pending: granted first cycle.
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        check("lit_first_cpu_gnt", 32'(bus.cpu_gnt), 1);
        drive(1, 0, 4'h3, 4'h0, 0, 0, 4'h0, 4'h0);
        check("lit_cpu_read_gnt", 32'(bus.cpu_gnt), 1);
        check("lit_cpu_read_ren", 32'(bus.sram_ren), 1);
        idle();
        check("lit_cpu_rvalid", 32'(bus.cpu_rvalid), 1);
        check("lit_cpu_rdata5", 32'(bus.rdata), 32'h5);
        check("lit_cpu_no_dma_rv", 32'(bus.dma_rvalid), 0);

        // Preload: DMA writes addr1=A, CPU writes addr2=3.
        drive(0, 0, 4'h0, 4'h0, 1, 1, 4'h1, 4'hA);
        drive(1, 1, 4'h2, 4'h3, 0, 0, 4'h0, 4'h0);
        idle();

        // Read tagging.
        drive(0, 0, 4'h0, 4'h0, 1, 0, 4'h1, 4'h0);
        drive(1, 0, 4'h2, 4'h0, 0, 0, 4'h0, 4'h0);
        check("lit_tag_dma_rv", 32'(bus.dma_rvalid), 1);
        check("lit_tag_dma_data", 32'(bus.rdata), 32'hA);
        idle();
        check("lit_tag_cpu_rv", 32'(bus.cpu_rvalid), 1);
        check("lit_tag_cpu_data", 32'(bus.rdata), 32'h3);

        // Simultaneous from idle: CPU wins, DMA follows once CPU drops.
        drive(1, 0, 4'h3, 4'h0, 1, 0, 4'h1, 4'h0);
        check("lit_sim_cpu", 32'({bus.cpu_gnt, bus.dma_gnt}), 32'b10);
        drive(0, 0, 4'h0, 4'h0, 1, 0, 4'h1, 4'h0);
        check("lit_sim_dma_next", 32'(bus.dma_gnt), 1);
        check("lit_sim_cpu_data", 32'(bus.rdata), 32'h5);
        idle();
        check("lit_sim_dma_data", 32'(bus.rdata), 32'hA);

        // Cancel: DMA write of addr5 loses and is withdrawn.
        drive(1, 1, 4'h4, 4'h7, 1, 1, 4'h5, 4'h9);
        check("lit_cancel_lose", 32'(bus.dma_gnt), 0);
        idle();
        check("lit_cancel_none", 32'({bus.dma_gnt, bus.sram_wen, bus.sram_ren}), 0);
        drive(1, 0, 4'h5, 4'h0, 0, 0, 4'h0, 4'h0);
        idle();
        check("lit_cancel_data", 32'(bus.rdata), 32'h0);
        check("lit_cancel_no_dmarv", 32'(bus.dma_rvalid), 0);

        // DMA burst bound against a waiting CPU.
        drive(0, 0, 4'h0, 4'h0, 1, 1, 4'h8, 4'h1);
        ndma = 0;
        got_cpu = 0;
        for (int k = 0; k < 12 && !got_cpu; k++) begin
            drive(1, 0, 4'h4, 4'h0, 1, 1, 4'(9 + ndma), 4'(ndma));
            check("lit_burst_busy", 32'(bus.busy), 1);
            if (bus.dma_gnt) ndma++;
            if (bus.cpu_gnt) got_cpu = 1;
        end
        check("lit_burst_cpu_won", 32'(got_cpu), 1);
        check("lit_burst_count", 32'(ndma), 32'd4);
        drive(0, 0, 4'h0, 4'h0, 1, 1, 4'(9 + ndma), 4'(ndma));
        check("lit_burst_dma_again", 32'(bus.dma_gnt), 1);
        check("lit_burst_cpu_data", 32'(bus.rdata), 32'h7);
        check("lit_burst_busy_cpu", 32'(bus.busy), 0);

        // Reset with a DMA read pending.
        drive(0, 0, 4'h0, 4'h0, 1, 0, 4'h1, 4'h0);
        check("lit_pre_rst_gnt", 32'(bus.dma_gnt), 1);
        @(posedge clk); #1;
        rst = 1; bus.dma_req = 0;
        #1;
        check("lit_midrst_outs", 32'({bus.cpu_gnt, bus.dma_gnt, bus.cpu_rvalid, bus.dma_rvalid, bus.busy,
                                      bus.sram_ren, bus.sram_wen, bus.sram_addr, bus.sram_wdata, bus.rdata}), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 0;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 4'h3;
        @(negedge clk);
        check("lit_post_rst_gnt", 32'(bus.cpu_gnt), 1);
        check("lit_post_rst_no_rv", 32'(bus.dma_rvalid), 0);
        idle();
        check("lit_post_rst_data", 32'(bus.rdata), 32'h5);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
